// File: rtl/multicycle_seq.sv
// Multi-cycle sequencer for the shared-memory-port RV32I core: walks each instruction
// through fetch/decode/exec/mem/writeback and raises the per-phase strobes.

package lib_pkg;
  typedef enum logic [3:0] {
    OP_LUI     = 4'd0,
    OP_AUIPC   = 4'd1,
    OP_JAL     = 4'd2,
    OP_JALR    = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_LOAD    = 4'd5,
    OP_STORE   = 4'd6,
    OP_OPIMM   = 4'd7,
    OP_OP      = 4'd8,
    OP_MISCMEM = 4'd9,
    OP_SYSTEM  = 4'd10
  } op_type_t;
endpackage

// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction read on the shared port, IR loads on ack
// DECODE | halt / legality check of the held instruction
// EXEC   | branch, fence and system retire here; others dispatch
// MEM    | data access on the shared port
// WB     | register-file write and retire
// HALT   | absorbing until reset
module multicycle_seq
  import lib_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  op_type_t         op_type,
  input  logic             cmp_res,
  input  logic             fin,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_wr_en,
  output logic             pc_wr_en,
  output logic             sel_pc,
  output logic             rf_wr_en,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t state_q;
  logic   halted_q;
  logic   illegal_q;

  logic op_legal;
  logic op_mem;
  logic op_wb;
  logic op_jump;
  logic retire;

  always_comb begin
    op_legal = 1'b1;
    op_mem   = 1'b0;
    op_wb    = 1'b0;
    op_jump  = 1'b0;
    case (op_type)
      OP_LOAD, OP_STORE: op_mem = 1'b1;
      OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP: op_wb = 1'b1;
      OP_JAL, OP_JALR: begin
        op_wb   = 1'b1;
        op_jump = 1'b1;
      end
      OP_BRANCH: op_jump = cmp_res;
      OP_MISCMEM, OP_SYSTEM: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  assign retire = ((state_q == S_EXEC) && !op_mem && !op_wb)
               || ((state_q == S_MEM) && mem_ack && (op_type == OP_STORE))
               || (state_q == S_WB);

  // Strobes are gated by rst so a reset mid-access kills the request in the same cycle.
  assign mem_req      = !rst && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we       = !rst && (state_q == S_MEM) && (op_type == OP_STORE);
  assign mem_addr_sel = !rst && (state_q == S_MEM);
  assign ir_wr_en     = !rst && (state_q == S_FETCH) && mem_ack;
  assign pc_wr_en     = !rst && retire;
  assign sel_pc       = pc_wr_en && op_jump;
  assign rf_wr_en     = !rst && (state_q == S_WB);
  assign halted       = halted_q;
  assign illegal      = illegal_q;
  assign state        = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if ((state_q != S_IDLE) && (state_q != S_HALT))
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire)
        instret_cnt <= instret_cnt + CNT_W'(1);

      case (state_q)
        S_IDLE:  if (run) state_q <= S_FETCH;
        S_FETCH: if (mem_ack) state_q <= S_DECODE;
        S_DECODE: begin
          if (fin) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (!op_legal) begin
            state_q   <= S_HALT;
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_mem)     state_q <= S_MEM;
          else if (op_wb) state_q <= S_WB;
          else            state_q <= run ? S_FETCH : S_IDLE;
        end
        S_MEM: begin
          if (mem_ack) begin
            if (op_type == OP_STORE) state_q <= run ? S_FETCH : S_IDLE;
            else                     state_q <= S_WB;
          end
        end
        S_WB:    state_q <= run ? S_FETCH : S_IDLE;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
